fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer_pkg.sv | 29 ++
 rtl/fifo_rd_outreg.sv | 43 ++++
 rtl/fifo_rd_packer.sv | 123 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side byte packer.
package fifo_rd_packer_pkg;

    localparam int MAX_LANES = 64;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PARK = 1'b1
    } pk_state_t;

    // acnt must reach NBYTES itself, hence the +1
    function automatic int acnt_width(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction

    function automatic int tmr_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic logic [MAX_LANES-1:0] keep_mask(input int cnt);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// Single-entry output register on a valid/ready stream, with emitted-word counter.
module fifo_rd_outreg
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int NBYTES = 4,
    parameter int CNTW   = 16
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    load,
    input  logic [DSIZE*NBYTES-1:0] load_data,
    input  logic [NBYTES-1:0]       load_keep,
    input  logic                    m_ready,
    output logic [DSIZE*NBYTES-1:0] m_data,
    output logic [NBYTES-1:0]       m_keep,
    output logic                    m_valid,
    output logic [CNTW-1:0]         word_cnt,
    output logic                    slot_free
);

    assign slot_free = !m_valid || m_ready;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            m_data   <= '0;
            m_keep   <= '0;
            m_valid  <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (m_valid && m_ready) word_cnt <= word_cnt + CNTW'(1);
            // a load on the retiring cycle keeps m_valid high back-to-back
            if (load) begin
                m_data  <= load_data;
                m_keep  <= load_keep;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into words.
//   state   | meaning
//   ST_FILL | popping bytes into the assembly register (acnt < NBYTES)
//   ST_PARK | full word held in assembly, waiting for the output slot
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE         = 8,
    parameter int NBYTES        = 4,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int CNTW          = 16
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    input  logic [DSIZE-1:0]        rdata,
    output logic                    rinc,
    input  logic                    flush,
    output logic [DSIZE*NBYTES-1:0] m_data,
    output logic [NBYTES-1:0]       m_keep,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CNTW-1:0]         word_cnt
);

    localparam int ACNTW = acnt_width(NBYTES);
    localparam int TMRW  = tmr_width(FLUSH_TIMEOUT);
    localparam logic [ACNTW-1:0] ACNT_FULL = ACNTW'(NBYTES);
    localparam logic [ACNTW-1:0] ACNT_LAST = ACNTW'(NBYTES - 1);
    localparam logic [TMRW-1:0]  TMR_END   = TMRW'(FLUSH_TIMEOUT - 1);

    pk_state_t                     state, state_nxt;
    logic [ACNTW-1:0]              acnt;
    logic [NBYTES-1:0][DSIZE-1:0]  asm_q;
    logic [NBYTES-1:0][DSIZE-1:0]  asm_wr;
    logic [TMRW-1:0]               timer;
    logic                          flush_pend;

    logic                          pop, last_byte, held, flush_req;
    logic                          full_load, part_load, load, slot_free;
    logic [DSIZE*NBYTES-1:0]       load_data;
    logic [NBYTES-1:0]             load_keep;

    always_ff @(posedge rclk) begin
        if (rrst) state <= ST_FILL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: if (last_byte && !slot_free) state_nxt = ST_PARK;
            ST_PARK: if (slot_free)               state_nxt = ST_FILL;
            default:                              state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        pop       = !rrst && !rempty && (acnt < ACNT_FULL);
        last_byte = pop && (acnt == ACNT_LAST);
        held      = (acnt != '0) && (acnt < ACNT_FULL);
        flush_req = flush_pend || flush || (timer == TMR_END);
        full_load = slot_free && ((state == ST_FILL && last_byte) || state == ST_PARK);
        part_load = slot_free && held && !pop && flush_req;
        load      = full_load || part_load;

        asm_wr = asm_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (pop && acnt == ACNTW'(i)) asm_wr[i] = rdata;
        end

        load_keep = full_load ? '1 : NBYTES'(keep_mask(int'(acnt)));
        load_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            load_data[i*DSIZE +: DSIZE] = load_keep[i] ? asm_wr[i] : '0;
        end
    end

    assign rinc = pop;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            acnt       <= '0;
            asm_q      <= '0;
            timer      <= '0;
            flush_pend <= 1'b0;
        end else if (load) begin
            acnt       <= '0;
            asm_q      <= '0;
            timer      <= '0;
            flush_pend <= 1'b0;
        end else begin
            // a completing byte that parks still lands here, so acnt reaches NBYTES
            if (pop) begin
                acnt  <= acnt + ACNTW'(1);
                asm_q <= asm_wr;
                timer <= '0;
            end else if (held && rempty && timer != TMR_END) begin
                timer <= timer + TMRW'(1);
            end
            if (flush && acnt != '0) flush_pend <= 1'b1;
        end
    end

    fifo_rd_outreg #(
        .DSIZE  (DSIZE),
        .NBYTES (NBYTES),
        .CNTW   (CNTW)
    ) u_outreg (
        .rclk      (rclk),
        .rrst      (rrst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .word_cnt  (word_cnt),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO model, scoreboard of expected words.
module tb_fifo_rd_packer;

    localparam int TO = 16;

    logic        rclk, rrst, rempty, rinc, flush, m_valid, m_ready;
    logic [7:0]  rdata;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [15:0] word_cnt;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        s_rinc, s_valid, popped;
    logic        hold_prev;
    logic [31:0] hold_data;
    logic [3:0]  hold_keep;

    fifo_rd_packer #(
        .DSIZE(8), .NBYTES(4), .FLUSH_TIMEOUT(TO), .CNTW(16)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .flush    (flush),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .word_cnt (word_cnt)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        exp_q.push_back(e);
    endtask

    // sample on the falling edge, let the FIFO model react just after the rising edge
    task automatic tick();
        exp_t e;
        @(negedge rclk);
        s_rinc  = rinc;
        s_valid = m_valid;
        popped  = rinc;
        if (hold_prev && !rrst) begin
            check("hold_data",  64'(m_data),  64'(hold_data));
            check("hold_keep",  64'(m_keep),  64'(hold_keep));
            check("hold_valid", 64'(m_valid), 64'd1);
        end
        hold_prev = m_valid && !m_ready && !rrst;
        hold_data = m_data;
        hold_keep = m_keep;
        if (m_valid && m_ready && !rrst) begin
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("word_data", 64'(m_data), 64'(e.d));
                check("word_keep", 64'(m_keep), 64'(e.k));
            end
        end
        @(posedge rclk);
        #1;
        if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;
        rclk = 1'b0; rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        hold_prev = 1'b0; hold_data = '0; hold_keep = '0;
        refresh();

        // reset state, with data already waiting in the FIFO
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        tick(); tick();
        check("rst_rinc",     64'(s_rinc),   64'd0);
        check("rst_valid",    64'(m_valid),  64'd0);
        check("rst_data",     64'(m_data),   64'd0);
        check("rst_keep",     64'(m_keep),   64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);

        // streaming
        expect_word(32'h44332211, 4'hF);
        expect_word(32'h88776655, 4'hF);
        rrst = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_rinc", 64'(s_rinc), 64'd1);
        end
        repeat (3) tick();
        check("stream_rinc_idle", 64'(s_rinc),        64'd0);
        check("stream_drained",   64'(exp_q.size()),  64'd0);
        check("stream_cnt",       64'(word_cnt),      64'd2);

        // backpressure
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        expect_word(32'h44332211, 4'hF);
        expect_word(32'h88776655, 4'hF);
        repeat (10) tick();
        check("bp_rinc_parked", 64'(s_rinc),         64'd0);
        check("bp_fifo_empty",  64'(fifo_q.size()),  64'd0);
        check("bp_held_data",   64'(m_data),         64'h44332211);
        check("bp_held_valid",  64'(m_valid),        64'd1);
        m_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_cnt",     64'(word_cnt),     64'd4);
        check("bp_idle",    64'(m_valid),      64'd0);

        // idle timeout on a 3-byte partial
        push(8'h11); push(8'h22); push(8'h33);
        expect_word(32'h00332211, 4'h7);
        n = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (s_valid) seen = 1'b1;
        end
        check("to_seen",    64'(seen), 64'd1);
        check("to_latency", 64'(n),    64'(3 + TO + 1));
        repeat (2) tick();
        check("to_drained", 64'(exp_q.size()), 64'd0);
        check("to_cnt",     64'(word_cnt),     64'd5);

        // flush while an earlier word is stalled
        m_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hA1); push(8'hB2);
        expect_word(32'hC4C3C2C1, 4'hF);
        expect_word(32'h0000B2A1, 4'h3);
        repeat (8) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        check("fl_stalled", 64'(m_data),       64'hC4C3C2C1);
        check("fl_pending", 64'(exp_q.size()), 64'd2);
        m_ready = 1'b1;
        repeat (2) tick();
        check("fl_drained", 64'(exp_q.size()), 64'd0);
        check("fl_cnt",     64'(word_cnt),     64'd7);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (4) tick();
        check("fl_idle_valid", 64'(m_valid),  64'd0);
        check("fl_idle_cnt",   64'(word_cnt), 64'd7);

        // flush on the cycle the completing byte pops
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        expect_word(32'hD4D3D2D1, 4'hF);
        repeat (3) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (TO + 6) tick();
        check("col_drained", 64'(exp_q.size()), 64'd0);
        check("col_cnt",     64'(word_cnt),     64'd8);
        check("col_valid",   64'(m_valid),      64'd0);

        // reset mid-word with a stalled output word
        m_ready = 1'b0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4); push(8'hF1); push(8'hF2);
        expect_word(32'hE4E3E2E1, 4'hF);
        repeat (8) tick();
        check("rm_pre_valid", 64'(m_valid), 64'd1);
        rrst = 1'b1;
        exp_q.delete();
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        tick();
        check("rm_rinc",     64'(s_rinc),   64'd0);
        check("rm_valid",    64'(m_valid),  64'd0);
        check("rm_word_cnt", 64'(word_cnt), 64'd0);
        check("rm_keep",     64'(m_keep),   64'd0);
        tick();
        check("rm_rinc2",    64'(s_rinc),   64'd0);
        rrst = 1'b0; m_ready = 1'b1;
        expect_word(32'h34333231, 4'hF);
        repeat (8) tick();
        check("rm_drained", 64'(exp_q.size()), 64'd0);
        check("rm_cnt",     64'(word_cnt),     64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
